// File: rtl/axis_frame_host_pkg.sv
// Shared definitions for the host-side AXIS frame driver.
// Defaults match the accelerator wrapper so both ends of the link agree.
package axis_frame_host_pkg;

   localparam int unsigned STATE_WIDTH    = 2;
   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned TX_NUM_DEF     = 8;
   localparam int unsigned RX_NUM_DEF     = 4;

   typedef enum logic [STATE_WIDTH-1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      RECV = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/axis_frame_host_if.sv
// Paired AXIS links between the host driver (master modport) and the accelerator side (slave modport).
interface axis_frame_host_if
   import axis_frame_host_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_last;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_last;
   logic                  s_ready;

   modport master (
      output m_data, m_valid, m_last,
      input  m_ready,
      input  s_data, s_valid, s_last,
      output s_ready
   );

   modport slave (
      input  m_data, m_valid, m_last,
      output m_ready,
      output s_data, s_valid, s_last,
      input  s_ready
   );
endinterface

// File: rtl/axis_frame_host_frame_buffer.sv
// Word buffer with one synchronous write port and one asynchronous read port.
// Out-of-range addresses neither write nor read (read returns zero).
module axis_frame_host_frame_buffer #(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  wr,
   input  logic [ADR_WIDTH-1:0]  wrAdr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADR_WIDTH-1:0]  rdAdr,
   output logic [DATA_WIDTH-1:0] dout
);
   localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_WIDTH-1:0]  wrIdx;
   logic [IDX_WIDTH-1:0]  rdIdx;
   logic                  wrInRange;
   logic                  rdInRange;

   assign wrIdx     = IDX_WIDTH'(wrAdr);
   assign rdIdx     = IDX_WIDTH'(rdAdr);
   assign wrInRange = 32'(wrAdr) < 32'(DEPTH);
   assign rdInRange = 32'(rdAdr) < 32'(DEPTH);

   always_ff @(posedge clk) begin
      if (wr && wrInRange) mem[wrIdx] <= din;
   end

   assign dout = rdInRange ? mem[rdIdx] : '0;
endmodule

// File: rtl/axis_frame_host.sv
// Host-side frame exchange: streams a loaded tx frame out as AXIS master, then
// collects the result frame as AXIS slave, flagging length errors against s_last.
module axis_frame_host
   import axis_frame_host_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned TX_NUM       = TX_NUM_DEF,
   parameter int unsigned RX_NUM       = RX_NUM_DEF,
   parameter int unsigned TX_ADR_WIDTH = 8,
   parameter int unsigned RX_ADR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   axis_frame_host_if.master       bus,
   input  logic                    host_start,
   input  logic                    host_tx_wr,
   input  logic [TX_ADR_WIDTH-1:0] host_tx_adr,
   input  logic [DATA_WIDTH-1:0]   host_tx_data,
   input  logic [RX_ADR_WIDTH-1:0] host_rx_adr,
   output logic [DATA_WIDTH-1:0]   host_rx_data,
   output logic                    busy,
   output logic                    done,
   output logic                    err_len
);
   localparam logic [TX_ADR_WIDTH-1:0] TX_LAST = TX_ADR_WIDTH'(TX_NUM - 1);
   localparam logic [RX_ADR_WIDTH-1:0] RX_LAST = RX_ADR_WIDTH'(RX_NUM - 1);

   state_t                  state, nextState;
   logic [TX_ADR_WIDTH-1:0] txCnt, txCntNext;
   logic [RX_ADR_WIDTH-1:0] rxCnt, rxCntNext;
   logic                    errLen, errLenNext;
   logic                    txWr;
   logic                    rxWr;
   logic [DATA_WIDTH-1:0]   txRdData;

   // State and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         txCnt  <= '0;
         rxCnt  <= '0;
         errLen <= 1'b0;
      end else begin
         state  <= nextState;
         txCnt  <= txCntNext;
         rxCnt  <= rxCntNext;
         errLen <= errLenNext;
      end
   end

   // Next-state and buffer write control
   always_comb begin
      nextState  = state;
      txCntNext  = txCnt;
      rxCntNext  = rxCnt;
      errLenNext = errLen;
      txWr       = 1'b0;
      rxWr       = 1'b0;
      unique case (state)
         IDLE: begin
            txWr = host_tx_wr;
            if (host_start) begin
               nextState  = SEND;
               txCntNext  = '0;
               rxCntNext  = '0;
               errLenNext = 1'b0;
            end
         end
         SEND: begin
            if (bus.m_ready) begin
               // Counter returns to zero on the final beat so it never passes TX_NUM-1
               if (txCnt == TX_LAST) begin
                  txCntNext = '0;
                  nextState = RECV;
               end else begin
                  txCntNext = txCnt + TX_ADR_WIDTH'(1);
               end
            end
         end
         RECV: begin
            if (bus.s_valid) begin
               rxWr = 1'b1;
               if (rxCnt == RX_LAST) begin
                  nextState = DONE;
                  if (!bus.s_last) errLenNext = 1'b1;
               end else begin
                  rxCntNext = rxCnt + RX_ADR_WIDTH'(1);
                  if (bus.s_last) begin
                     errLenNext = 1'b1;
                     nextState  = DONE;
                  end
               end
            end
         end
         DONE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   axis_frame_host_frame_buffer #(
      .DEPTH     (TX_NUM),
      .ADR_WIDTH (TX_ADR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) txBuf (
      .clk  (clk),
      .wr   (txWr),
      .wrAdr(host_tx_adr),
      .din  (host_tx_data),
      .rdAdr(txCnt),
      .dout (txRdData)
   );

   axis_frame_host_frame_buffer #(
      .DEPTH     (RX_NUM),
      .ADR_WIDTH (RX_ADR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) rxBuf (
      .clk  (clk),
      .wr   (rxWr),
      .wrAdr(rxCnt),
      .din  (bus.s_data),
      .rdAdr(host_rx_adr),
      .dout (host_rx_data)
   );

   // Handshake outputs decode directly from the state register
   assign bus.m_valid = (state == SEND);
   assign bus.m_last  = (state == SEND) && (txCnt == TX_LAST);
   assign bus.m_data  = txRdData;
   assign bus.s_ready = (state == RECV);
   assign busy        = (state == SEND) || (state == RECV);
   assign done        = (state == DONE);
   assign err_len     = errLen;
endmodule

// File: tb/tb_axis_frame_host.sv
// Directed bench for axis_frame_host: normal exchange, backpressure, short/long
// result frames, ignored host requests while busy, and reset mid-frame.
module tb_axis_frame_host;
   import axis_frame_host_pkg::*;

   localparam int unsigned DW  = 32;
   localparam int unsigned TXA = 8;
   localparam int unsigned RXA = 8;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           host_start = 1'b0;
   logic           host_tx_wr = 1'b0;
   logic [TXA-1:0] host_tx_adr = '0;
   logic [DW-1:0]  host_tx_data = '0;
   logic [RXA-1:0] host_rx_adr = '0;
   logic [DW-1:0]  host_rx_data;
   logic           busy;
   logic           done;
   logic           err_len;

   int errors = 0;
   int checks = 0;

   axis_frame_host_if #(.DATA_WIDTH(DW)) axis ();

   axis_frame_host #(
      .DATA_WIDTH  (DW),
      .TX_NUM      (8),
      .RX_NUM      (4),
      .TX_ADR_WIDTH(TXA),
      .RX_ADR_WIDTH(RXA)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (axis),
      .host_start  (host_start),
      .host_tx_wr  (host_tx_wr),
      .host_tx_adr (host_tx_adr),
      .host_tx_data(host_tx_data),
      .host_rx_adr (host_rx_adr),
      .host_rx_data(host_rx_data),
      .busy        (busy),
      .done        (done),
      .err_len     (err_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, "_m_valid"}, 32'(axis.m_valid), 32'd0);
      check({tag, "_m_last"},  32'(axis.m_last),  32'd0);
      check({tag, "_s_ready"}, 32'(axis.s_ready), 32'd0);
      check({tag, "_busy"},    32'(busy),         32'd0);
      check({tag, "_done"},    32'(done),         32'd0);
      check({tag, "_err_len"}, 32'(err_len),      32'd0);
   endtask

   task automatic loadTx();
      for (int i = 0; i < 8; i++) begin
         host_tx_wr   = 1'b1;
         host_tx_adr  = TXA'(i);
         host_tx_data = 32'(i + 1);
         step();
      end
      host_tx_wr = 1'b0;
   endtask

   task automatic startFrame();
      host_start = 1'b1;
      check("m_valid_pre_start", 32'(axis.m_valid), 32'd0);
      step();
      host_start = 1'b0;
      check("m_valid_first", 32'(axis.m_valid), 32'd1);
      check("busy_send", 32'(busy), 32'd1);
      check("err_len_cleared", 32'(err_len), 32'd0);
   endtask

   // readyPat bit c gives m_ready on send cycle c; poke issues host requests on cycle 1
   task automatic sendFrame(input logic [15:0] readyPat, input int expCycles, input bit poke);
      int  k = 0;
      int  c = 0;
      logic xfer;
      while (k < 8 && c < 40) begin
         axis.m_ready = (c < 16) ? readyPat[c] : 1'b1;
         if (poke && c == 1) begin
            host_start   = 1'b1;
            host_tx_wr   = 1'b1;
            host_tx_adr  = '0;
            host_tx_data = 32'hFFFF;
         end
         check("m_valid", 32'(axis.m_valid), 32'd1);
         check("m_data", axis.m_data, 32'(k + 1));
         check("m_last", 32'(axis.m_last), 32'(k == 7));
         check("s_ready_in_send", 32'(axis.s_ready), 32'd0);
         xfer = axis.m_ready;
         step();
         host_start = 1'b0;
         host_tx_wr = 1'b0;
         c++;
         if (xfer) k++;
      end
      check("send_words", 32'(k), 32'd8);
      check("send_cycles", 32'(c), 32'(expCycles));
      axis.m_ready = 1'b0;
      check("m_valid_after_send", 32'(axis.m_valid), 32'd0);
      check("s_ready_recv", 32'(axis.s_ready), 32'd1);
   endtask

   // Drives nBeats words base+j; s_last on beat lastAt; DUT should accept expAccepted then pulse done
   task automatic recvFrame(input logic [31:0] base, input int nBeats, input int lastAt,
                            input int expAccepted, input bit expErr);
      for (int j = 0; j < nBeats; j++) begin
         axis.s_valid = 1'b1;
         axis.s_data  = base + 32'(j);
         axis.s_last  = (j == lastAt);
         check("s_ready_beat", 32'(axis.s_ready), 32'(j < expAccepted));
         step();
         if (j == expAccepted - 1) begin
            check("done_pulse", 32'(done), 32'd1);
            check("busy_done", 32'(busy), 32'd0);
            check("s_ready_done", 32'(axis.s_ready), 32'd0);
            check("err_len_done", 32'(err_len), 32'(expErr));
         end
      end
      axis.s_valid = 1'b0;
      axis.s_last  = 1'b0;
      if (nBeats == expAccepted) step();
      check("done_cleared", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("err_len_sticky", 32'(err_len), 32'(expErr));
   endtask

   task automatic checkRx(input int idx, input logic [31:0] exp);
      host_rx_adr = RXA'(idx);
      #1;
      check("rx_read", host_rx_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      axis.m_ready = 1'b0;
      axis.s_valid = 1'b0;
      axis.s_last  = 1'b0;
      axis.s_data  = '0;
      #1;
      checkIdleOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Normal exchange
      loadTx();
      startFrame();
      sendFrame(16'hFFFF, 8, 1'b0);
      recvFrame(32'hA000_0000, 4, 3, 4, 1'b0);
      for (int j = 0; j < 4; j++) checkRx(j, 32'hA000_0000 + 32'(j));

      // Backpressure 1,0,0,1 with ignored start/write during a stall
      startFrame();
      sendFrame(16'hFFF9, 10, 1'b1);
      recvFrame(32'hB000_0000, 4, 3, 4, 1'b0);
      checkRx(3, 32'hB000_0003);

      // Short result frame: s_last on second beat
      startFrame();
      sendFrame(16'hFFFF, 8, 1'b0);
      recvFrame(32'hC000_0000, 2, 1, 2, 1'b1);
      checkRx(0, 32'hC000_0000);
      checkRx(1, 32'hC000_0001);
      checkRx(2, 32'hB000_0002);

      // Long result frame: no s_last, extra words offered afterwards
      startFrame();
      sendFrame(16'hFFFF, 8, 1'b0);
      recvFrame(32'hD000_0000, 6, 99, 4, 1'b1);
      checkRx(0, 32'hD000_0000);
      checkRx(3, 32'hD000_0003);

      // Reset while the third word is on the bus
      startFrame();
      axis.m_ready = 1'b1;
      step();
      step();
      check("m_data_before_reset", axis.m_data, 32'd3);
      rst_n = 1'b0;
      #1;
      checkIdleOutputs("midreset");
      axis.m_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      startFrame();
      sendFrame(16'hFFFF, 8, 1'b0);
      recvFrame(32'hE000_0000, 4, 3, 4, 1'b0);
      checkRx(2, 32'hE000_0002);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axis_frame_host.md
Name: axis_frame_host

Overview:
- Host-side counterpart of the accelerator AXI-Stream wrapper.
- Holds one input frame loaded by a host/testbench port and transmits it as an AXIS master: TX_NUM words, m_last on the final word.
- Then receives the RX_NUM-word result frame as an AXIS slave into a result buffer, checks frame length against s_last, and pulses done.
- Used as the on-chip driver and self-test harness for the CNN core wrapper.

Parameters:
- DATA_WIDTH, 32, stream and buffer word width
- TX_NUM, 8, words per transmitted frame (≥1)
- RX_NUM, 4, words per received frame (≥1)
- TX_ADR_WIDTH, 8, tx buffer/counter address width (2^TX_ADR_WIDTH ≥ TX_NUM)
- RX_ADR_WIDTH, 8, rx buffer/counter address width (2^RX_ADR_WIDTH ≥ RX_NUM)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_data  out  DATA_WIDTH  master stream data
- m_valid  out  1  master valid
- m_last  out  1  final word of tx frame
- m_ready  in  1  downstream ready
- s_data  in  DATA_WIDTH  slave stream data
- s_valid  in  1  upstream valid
- s_last  in  1  upstream end of frame
- s_ready  out  1  slave ready
- host_start  in  1  single-cycle request to run one frame exchange
- host_tx_wr  in  1  tx buffer write enable
- host_tx_adr  in  TX_ADR_WIDTH  tx buffer write address
- host_tx_data  in  DATA_WIDTH  tx buffer write data
- host_rx_adr  in  RX_ADR_WIDTH  rx buffer read address
- host_rx_data  out  DATA_WIDTH  rx buffer read data, combinational
- busy  out  1  exchange in progress
- done  out  1  one-cycle pulse at end of exchange
- err_len  out  1  sticky length error from last exchange

Behaviour:
- Reset value of every output: m_valid=0, m_last=0, s_ready=0, busy=0, done=0, err_len=0. Counters=0, state=IDLE. Buffer arrays are not reset.
- States: IDLE, SEND, RECV, DONE (2-bit encoding).
- IDLE:
  - host_tx_wr writes tx buffer at the next edge.
  - host_start → SEND; tx_cnt and rx_cnt cleared; err_len cleared.
- SEND (busy=1):
  - m_valid=1, m_data=txbuf[tx_cnt], m_last=(tx_cnt==TX_NUM-1).
  - On m_valid&m_ready: tx_cnt+1. If that beat had m_last=1 → RECV.
  - While m_ready=0: m_data and m_last hold stable.
  - m_valid is never dropped mid-frame.
- RECV (busy=1):
  - s_ready=1. On s_valid: rxbuf[rx_cnt]<=s_data, rx_cnt+1.
  - Beat at rx_cnt==RX_NUM-1 → DONE. If s_last=0 on that beat, set err_len.
  - s_last=1 on a beat with rx_cnt<RX_NUM-1: word stored, err_len set, → DONE (short frame).
- DONE: done=1, busy=0, s_ready=0 for exactly one cycle → IDLE.
- Latency:
  - First m_valid occurs one cycle after host_start is sampled.
  - With m_ready and s_valid held high: TX_NUM send cycles, RX_NUM receive cycles, then 1 DONE cycle.
- Boundary conditions:
  - host_start while busy: ignored.
  - host_tx_wr while busy: ignored (no buffer write).
  - host_rx_adr reads are allowed at any time; read data mid-RECV is unspecified.
  - s_valid outside RECV: ignored; s_ready=0.
  - Extra words after a frame completes: not accepted, since s_ready is low in DONE/IDLE.
  - TX_NUM=1: single beat with m_last=1.
  - RX_NUM=1: single beat, which must carry s_last=1.
  - Counters never exceed NUM-1; a new start clears them (no wrap reuse).
  - Reset mid-operation: immediate return to IDLE, outputs to reset values; a partial frame on the bus is abandoned.

Decomposition:
- Shared package holds:
  - state localparams (IDLE/SEND/RECV/DONE, STATE_WIDTH=2);
  - default DATA_WIDTH / TX_NUM / RX_NUM, matching the accelerator wrapper defaults so both ends agree.
- One sub-module, frame_buffer: register array of N×DATA_WIDTH with sync write (wr, adr, din) and async read (adr → dout). Instantiated twice: tx buffer and rx buffer.
- Address counters stay inline.

Test Plan:
- Load tx words 1..8, host_start, m_ready=1, source returns 4 words A0..A3 with s_last on the 4th.
  - m_data 1..8 on consecutive cycles, m_last only with word 8.
  - RECV accepts 4 beats; done pulses once; err_len=0; host_rx_adr 0..3 reads A0..A3.
- Backpressure: toggle m_ready 1,0,0,1 during send.
  - m_data/m_last hold while ready=0; each word is transferred exactly once.
  - Total send cycles = 8 + number of stall cycles.
- Short frame: s_last asserted on the 2nd rx beat → 2 words stored, err_len=1, done pulse, back to IDLE.
- Long frame: 4th rx beat has s_last=0 → err_len=1, done, s_ready=0 afterwards.
  - 5th word not accepted; rxbuf[3] holds the 4th word.
- host_start and host_tx_wr (adr 0, data FFFF) during SEND are ignored: frame unchanged, txbuf[0] unchanged after done.
- rst_n low mid-SEND at word 3: outputs go to 0 immediately. After release, a new host_start sends from word 1 with err_len=0.
